// File: rtl/cf_frame_loader.sv
// ----------------------------------------------------------------------------
// cf_frame_loader
//   Input framing stage for the six-lane butterfly/scaling stage. Accepts a
//   serial stream of W-bit two's-complement samples over valid/ready and
//   converts each one to sign-magnitude when it is accepted. Six samples are
//   collected in a fill bank, and the complete frame is then published on
//   six parallel outputs. Those outputs hold their value until the next
//   publish. A delayed valid marks the cycle in which the butterfly's
//   registered outputs correspond to a published frame.
//
// Ports
//   i_clk        clock, rising edge
//   i_reset_n    synchronous active-low reset
//   i_s_data     W-bit two's-complement input sample
//   i_s_valid    i_s_data valid
//   i_s_last     frame marker, legal only on the 6th sample
//   o_s_ready    sample accepted this cycle when high together with valid
//   i_hold       downstream stall, blocks publishing a new frame
//   o_d0..o_d5   published frame, sign-magnitude (o_d0 = 1st sample)
//   o_d_valid    one-cycle pulse in the first cycle a new frame is on o_d*
//   o_r_valid    o_d_valid delayed by ALIGN_DELAY cycles
//   o_frame_cnt  published frame count, wraps at 256
//   o_err        one-cycle pulse when a short frame is discarded
//   o_sat        one-cycle pulse when an accepted sample saturated
// ----------------------------------------------------------------------------
module cf_frame_loader #(
   parameter int unsigned W           = 12,
   parameter int unsigned ALIGN_DELAY = 2
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic [W-1:0] i_s_data,
   input  logic         i_s_valid,
   input  logic         i_s_last,
   output logic         o_s_ready,
   input  logic         i_hold,
   output logic [W-1:0] o_d0,
   output logic [W-1:0] o_d1,
   output logic [W-1:0] o_d2,
   output logic [W-1:0] o_d3,
   output logic [W-1:0] o_d4,
   output logic [W-1:0] o_d5,
   output logic         o_d_valid,
   output logic         o_r_valid,
   output logic [7:0]   o_frame_cnt,
   output logic         o_err,
   output logic         o_sat
);

   typedef enum logic {FILL, FULL} state_t;

   state_t                 r_state, w_state_nxt;
   logic [2:0]             r_idx;
   logic [W-1:0]           r_buf [6];
   logic [W-1:0]           r_d   [6];
   logic [7:0]             r_cnt;
   logic                   r_d_valid, r_err, r_sat;
   logic [ALIGN_DELAY-1:0] r_dly;

   logic         w_publish, w_xfer, w_discard, w_write;
   logic [2:0]   w_slot;
   logic         w_neg, w_sat_in;
   logic [W-1:0] w_abs, w_sm;

   // Sign-magnitude conversion. The most negative value has no positive
   // counterpart, so it clamps to the largest magnitude and flags saturation.
   assign w_neg    = i_s_data[W-1];
   assign w_abs    = w_neg ? (~i_s_data + 1'b1) : i_s_data;
   assign w_sat_in = w_neg & (i_s_data[W-2:0] == '0);
   assign w_sm     = {w_neg, (w_sat_in ? {(W-1){1'b1}} : w_abs[W-2:0])};

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) r_state <= FILL;
      else            r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FILL: if (w_write && (w_slot == 3'd5)) w_state_nxt = FULL;
         FULL: if (!i_hold)                     w_state_nxt = FILL;
         default: w_state_nxt = FILL;
      endcase
   end

   // Output / control logic
   always_comb begin
      o_s_ready = 1'b0;
      w_publish = 1'b0;
      case (r_state)
         FILL: o_s_ready = i_reset_n;
         FULL: begin
            o_s_ready = i_reset_n & ~i_hold;
            w_publish = ~i_hold;
         end
         default: ;
      endcase
   end

   // A sample accepted on the publish edge lands in slot 0 of the next frame.
   assign w_slot    = (r_state == FULL) ? 3'd0 : r_idx;
   assign w_xfer    = i_s_valid & o_s_ready;
   assign w_discard = w_xfer & i_s_last & (w_slot != 3'd5);
   assign w_write   = w_xfer & ~w_discard;

   // Datapath: fill bank, published frame, counters and pulses
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_idx     <= '0;
         r_cnt     <= '0;
         r_d_valid <= 1'b0;
         r_err     <= 1'b0;
         r_sat     <= 1'b0;
         for (int unsigned i = 0; i < 6; i++) r_d[i] <= '0;
      end else begin
         r_d_valid <= w_publish;
         r_err     <= w_discard;
         r_sat     <= w_xfer & w_sat_in;
         if (w_publish) begin
            for (int unsigned i = 0; i < 6; i++) r_d[i] <= r_buf[i];
            r_cnt <= r_cnt + 8'd1;
         end
         if (w_discard) begin
            r_idx <= '0;
         end else if (w_write) begin
            r_buf[w_slot] <= w_sm;
            r_idx         <= (w_slot == 3'd5) ? 3'd0 : w_slot + 3'd1;
         end
      end
   end

   // Alignment shift register for the downstream valid
   generate
      if (ALIGN_DELAY == 1) begin : g_dly1
         always_ff @(posedge i_clk) begin
            if (!i_reset_n) r_dly <= '0;
            else            r_dly <= r_d_valid;
         end
      end else begin : g_dlyn
         always_ff @(posedge i_clk) begin
            if (!i_reset_n) r_dly <= '0;
            else            r_dly <= {r_dly[ALIGN_DELAY-2:0], r_d_valid};
         end
      end
   endgenerate

   assign o_d0        = r_d[0];
   assign o_d1        = r_d[1];
   assign o_d2        = r_d[2];
   assign o_d3        = r_d[3];
   assign o_d4        = r_d[4];
   assign o_d5        = r_d[5];
   assign o_d_valid   = r_d_valid;
   assign o_r_valid   = r_dly[ALIGN_DELAY-1];
   assign o_frame_cnt = r_cnt;
   assign o_err       = r_err;
   assign o_sat       = r_sat;

endmodule
